// File: rtl/hazard_tracker_pkg.sv
// Shared types and encodings for the D/E/M/W hazard scoreboard.
// Forwarding-select codes, the "source unused" Tuse value and the per-stage writer slot.
package hazard_tracker_pkg;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

   localparam logic [2:0] TUSE_NONE = 3'd3;

   typedef struct packed {
      logic [4:0] addr;
      logic [1:0] tnew;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

   // One pipeline step older: tnew counts down and sticks at 0.
   function automatic slot_t age_slot(input slot_t s);
      slot_t r;
      r = s;
      if (s.tnew != 2'd0) begin
         r.tnew = s.tnew - 2'd1;
      end
      return r;
   endfunction

   // match/ready bit 0 = E, 1 = M, 2 = W; the youngest matching writer decides,
   // and a matching writer that is not ready yet hides every older one.
   function automatic logic [1:0] fwd_select(input logic [2:0] match, input logic [2:0] ready);
      logic [1:0] sel;
      sel = FWD_RF;
      if (match[0]) begin
         sel = ready[0] ? FWD_E : FWD_RF;
      end else if (match[1]) begin
         sel = ready[1] ? FWD_M : FWD_RF;
      end else if (match[2]) begin
         sel = ready[2] ? FWD_W : FWD_RF;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// D-stage hazard fields into the tracker, stall/forward selects and stall count back out.
// master = decode/pipeline control side, slave = hazard_tracker.
interface hazard_tracker_if #(
   parameter int CNT_W = 16
);

   logic [4:0]       D_rs;
   logic [4:0]       D_rt;
   logic [2:0]       D_Tuse_rs;
   logic [2:0]       D_Tuse_rt;
   logic [4:0]       D_wr_addr;
   logic             D_wr_en;
   logic [2:0]       D_Tnew;

   logic             stall;
   logic [1:0]       D_fwd_rs;
   logic [1:0]       D_fwd_rt;
   logic [1:0]       E_fwd_rs;
   logic [1:0]       E_fwd_rt;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_wr_addr, D_wr_en, D_Tnew,
      input  stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, stall_count
   );

   modport slave (
      input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_wr_addr, D_wr_en, D_Tnew,
      output stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, stall_count
   );

endinterface

// File: rtl/hazard_slot_cmp.sv
// Compares one in-flight writer slot against one source register; purely combinational.
// match: same non-zero register; stall_hit: result not ready in time; fwd_hit: result ready now.
module hazard_slot_cmp
   import hazard_tracker_pkg::*;
(
   input  slot_t      slot,
   input  logic [4:0] src,
   input  logic [2:0] tuse,
   output logic       match,
   output logic       stall_hit,
   output logic       fwd_hit
);

   always_comb begin
      match     = (slot.addr != 5'd0) && (slot.addr == src);
      stall_hit = match && ({1'b0, slot.tnew} > tuse);
      fwd_hit   = match && (slot.tnew == 2'd0);
   end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks writers in E/M/W, drives D stall plus D/E forward selects combinationally (0 latency).
// stall_count is registered one edge behind stall and saturates; async active-low reset empties all slots.
module hazard_tracker
   import hazard_tracker_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   hazard_tracker_if.slave hz
);

   slot_t            e_q, e_d;
   slot_t            m_q, m_d;
   slot_t            w_q, w_d;
   logic [4:0]       e_rs_q, e_rs_d;
   logic [4:0]       e_rt_q, e_rt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             stall;

   slot_t            stage_slot [3];
   logic [4:0]       d_src      [2];
   logic [2:0]       d_tuse     [2];
   logic [4:0]       e_src      [2];

   logic [2:0]       d_match     [2];
   logic [2:0]       d_stall_hit [2];
   logic [2:0]       d_fwd_hit   [2];
   logic [2:0]       e_match     [2];
   logic [2:0]       e_fwd_hit   [2];
   logic [2:1]       e_stall_hit [2];

   assign stage_slot[0] = e_q;
   assign stage_slot[1] = m_q;
   assign stage_slot[2] = w_q;

   assign d_src[0]  = hz.D_rs;
   assign d_src[1]  = hz.D_rt;
   assign d_tuse[0] = hz.D_Tuse_rs;
   assign d_tuse[1] = hz.D_Tuse_rt;
   assign e_src[0]  = e_rs_q;
   assign e_src[1]  = e_rt_q;

   // Index s selects the source (0 = rs, 1 = rt), g the stage (0 = E, 1 = M, 2 = W).
   for (genvar s = 0; s < 2; s++) begin : g_src
      for (genvar g = 0; g < 3; g++) begin : g_d_stage
         hazard_slot_cmp u_d_cmp (
            .slot      (stage_slot[g]),
            .src       (d_src[s]),
            .tuse      (d_tuse[s]),
            .match     (d_match[s][g]),
            .stall_hit (d_stall_hit[s][g]),
            .fwd_hit   (d_fwd_hit[s][g])
         );
      end

      assign e_match[s][0]   = 1'b0;
      assign e_fwd_hit[s][0] = 1'b0;

      for (genvar g = 1; g < 3; g++) begin : g_e_stage
         hazard_slot_cmp u_e_cmp (
            .slot      (stage_slot[g]),
            .src       (e_src[s]),
            .tuse      (TUSE_NONE),
            .match     (e_match[s][g]),
            .stall_hit (e_stall_hit[s][g]),
            .fwd_hit   (e_fwd_hit[s][g])
         );
      end
   end

   // W always has tnew = 0, so only E and M can hold up decode.
   assign stall = |{d_stall_hit[0][1:0], d_stall_hit[1][1:0]};

   assign hz.stall       = stall;
   assign hz.D_fwd_rs    = fwd_select(d_match[0], d_fwd_hit[0]);
   assign hz.D_fwd_rt    = fwd_select(d_match[1], d_fwd_hit[1]);
   assign hz.E_fwd_rs    = fwd_select(e_match[0], e_fwd_hit[0]);
   assign hz.E_fwd_rt    = fwd_select(e_match[1], e_fwd_hit[1]);
   assign hz.stall_count = cnt_q;

   always_comb begin
      e_d    = SLOT_EMPTY;
      e_rs_d = 5'd0;
      e_rt_d = 5'd0;
      if (!stall) begin
         e_d.addr = hz.D_wr_en ? hz.D_wr_addr : 5'd0;
         e_d.tnew = hz.D_Tnew[1:0];
         e_rs_d   = hz.D_rs;
         e_rt_d   = hz.D_rt;
      end

      m_d = age_slot(e_q);
      w_d = age_slot(m_q);

      cnt_d = cnt_q;
      if (stall && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q    <= SLOT_EMPTY;
         m_q    <= SLOT_EMPTY;
         w_q    <= SLOT_EMPTY;
         e_rs_q <= 5'd0;
         e_rt_q <= 5'd0;
         cnt_q  <= '0;
      end else begin
         e_q    <= e_d;
         m_q    <= m_d;
         w_q    <= w_d;
         e_rs_q <= e_rs_d;
         e_rt_q <= e_rt_d;
         cnt_q  <= cnt_d;
      end
   end

   logic unused_sigs;
   assign unused_sigs = ^{hz.D_Tnew[2], e_stall_hit[0], e_stall_hit[1],
                          d_stall_hit[0][2], d_stall_hit[1][2]};

endmodule
